// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep controller: state codes (also used by
// the db_estado 7-segment decode) and a constant-width helper.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    POSICIONA   = 4'h2,
    MEDE        = 4'h3,
    REPOSICIONA = 4'h4,
    TRANSMITE   = 4'h5,
    AGUARDA     = 4'hA,
    PROX_DIGITO = 4'hC,
    ESPERA      = 4'hE,
    FINAL       = 4'hF
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hB;

  // Minimum of one bit so that degenerate sizes still give a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sonar_contador_m.sv
// Modulo-M counter with synchronous clear; fim flags the terminal count M-1.
module sonar_contador_m
  import sonar_pkg::*;
#(
  parameter int M = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                zera,
  input  logic                conta,
  output logic [clog2(M)-1:0] q,
  output logic                fim
);

  localparam int W = clog2(M);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= fim ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == W'(M - 1));

endmodule

// File: rtl/sonar_varredura_uc.sv
// Sonar sweep control unit: ping-pong or single sweep over N_POS servo positions,
// with settle timer, echo watchdog and per-position frame transmission.
module sonar_varredura_uc
  import sonar_pkg::*;
#(
  parameter int N_POS     = 8,
  parameter int T_ASSENTA = 25000000,
  parameter int N_DIGITOS = 7,
  parameter int T_MEDIDA  = 12500000,
  localparam int AW = clog2(N_POS),
  localparam int DW = clog2(N_DIGITOS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ligar,
  input  logic          modo,
  input  logic          fim_medida,
  input  logic          silencio,
  input  logic          fim_digito,
  output logic          zera,
  output logic          comeca_medida,
  output logic          comeca_transmissao,
  output logic [DW-1:0] indice_digito,
  output logic [AW-1:0] angulo,
  output logic          direcao,
  output logic          erro_medida,
  output logic          fim_posicao,
  output logic          pronto,
  output logic [3:0]    db_estado
);

  localparam logic [AW-1:0] ANG_MAX = AW'(N_POS - 1);
  localparam logic [DW-1:0] DIG_MAX = DW'(N_DIGITOS - 1);

  estado_t estado, prox;
  logic fim_assenta, fim_watchdog;
  logic [clog2(T_ASSENTA)-1:0] assenta_q_unused;
  logic [clog2(T_MEDIDA)-1:0]  medida_q_unused;
  logic ultima_posicao;

  // Each timer restarts from zero on every entry into its own state.
  sonar_contador_m #(.M(T_ASSENTA)) u_assenta (
    .clock (clock),
    .reset (reset),
    .zera  (estado != POSICIONA),
    .conta (estado == POSICIONA),
    .q     (assenta_q_unused),
    .fim   (fim_assenta)
  );

  sonar_contador_m #(.M(T_MEDIDA)) u_watchdog (
    .clock (clock),
    .reset (reset),
    .zera  (estado != AGUARDA),
    .conta (estado == AGUARDA),
    .q     (medida_q_unused),
    .fim   (fim_watchdog)
  );

  assign ultima_posicao = modo && (angulo == ANG_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox               = estado;
    zera               = 1'b0;
    comeca_medida      = 1'b0;
    comeca_transmissao = 1'b0;
    fim_posicao        = 1'b0;
    pronto             = 1'b0;
    db_estado          = 4'(estado);
    case (estado)
      INICIAL: begin
        zera = 1'b1;
        if (ligar) prox = PREPARA;
      end
      PREPARA: begin
        zera = 1'b1;
        prox = POSICIONA;
      end
      POSICIONA: begin
        if (!ligar)           prox = FINAL;
        else if (fim_assenta) prox = MEDE;
      end
      MEDE: begin
        comeca_medida = 1'b1;
        prox          = AGUARDA;
      end
      // A measurement arriving on the watchdog's last cycle still counts.
      AGUARDA: begin
        if (fim_medida)        prox = silencio ? REPOSICIONA : TRANSMITE;
        else if (fim_watchdog) prox = REPOSICIONA;
      end
      TRANSMITE: begin
        comeca_transmissao = 1'b1;
        prox               = ESPERA;
      end
      ESPERA: begin
        if (fim_digito) prox = PROX_DIGITO;
      end
      PROX_DIGITO: begin
        prox = (indice_digito == DIG_MAX) ? REPOSICIONA : TRANSMITE;
      end
      REPOSICIONA: begin
        fim_posicao = 1'b1;
        prox        = ultima_posicao ? FINAL : POSICIONA;
      end
      FINAL: begin
        pronto = 1'b1;
        prox   = INICIAL;
      end
      default: begin
        db_estado = DB_INVALIDO;
        prox      = INICIAL;
      end
    endcase
  end

  // Angle turns around at either end so it never leaves 0..N_POS-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      angulo        <= '0;
      direcao       <= 1'b0;
      indice_digito <= '0;
      erro_medida   <= 1'b0;
    end else begin
      case (estado)
        PREPARA: begin
          angulo        <= '0;
          direcao       <= 1'b0;
          indice_digito <= '0;
          erro_medida   <= 1'b0;
        end
        MEDE: begin
          indice_digito <= '0;
          erro_medida   <= 1'b0;
        end
        AGUARDA: begin
          if (!fim_medida && fim_watchdog) erro_medida <= 1'b1;
        end
        PROX_DIGITO: begin
          if (indice_digito != DIG_MAX) indice_digito <= indice_digito + 1'b1;
        end
        REPOSICIONA: begin
          if (!ultima_posicao) begin
            if (!direcao) begin
              if (angulo == ANG_MAX) begin
                direcao <= 1'b1;
                angulo  <= angulo - 1'b1;
              end else begin
                angulo  <= angulo + 1'b1;
              end
            end else begin
              if (angulo == '0) begin
                direcao <= 1'b0;
                angulo  <= angulo + 1'b1;
              end else begin
                angulo  <= angulo - 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sonar_varredura_uc.md
Name: sonar_varredura_uc

Overview:
Parametrised sonar sweep controller, the successor to the fixed sonar control unit. It integrates its own timing, angle and digit counters, so the datapath no longer supplies fim_timeout, fim_envio or the angle counter. It adds a ping-pong (up/down) sweep, single-sweep and continuous modes, and an echo watchdog with an error flag. It sits between the top-level sonar, the ultrasonic measurement block and the serial transmitter.

Parameters:
N_POS, 8, servo positions per sweep (>=2); AW = $clog2(N_POS)
T_ASSENTA, 25000000, clock cycles spent in POSICIONA for servo settling (>=2)
N_DIGITOS, 7, characters transmitted per measurement frame (>=2); DW = $clog2(N_DIGITOS)
T_MEDIDA, 12500000, echo watchdog length in cycles (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; forces INICIAL
ligar  in  1  level; high starts and keeps the sweep running
modo  in  1  0 = continuous ping-pong, 1 = single sweep 0..N_POS-1 then stop
fim_medida  in  1  1-cycle pulse from the measurement block
silencio  in  1  sampled with fim_medida; 1 = skip transmission for this position
fim_digito  in  1  1-cycle pulse from the transmitter when a character is done
zera  out  1  datapath clear
comeca_medida  out  1  1-cycle trigger pulse
comeca_transmissao  out  1  1-cycle pulse per character
indice_digito  out  DW  character index to the frame mux
angulo  out  AW  current servo position index
direcao  out  1  0 = increasing, 1 = decreasing
erro_medida  out  1  watchdog expired at the current position
fim_posicao  out  1  1-cycle pulse when leaving a position
pronto  out  1  1-cycle pulse in FINAL
db_estado  out  4  state code

Behaviour:
- Reset (asynchronous): state INICIAL; angulo=0, direcao=0, indice_digito=0, erro_medida=0, all internal counters 0. Pulse outputs are combinational decodes of state and are 0 except zera=1.
- State codes: INICIAL 0, PREPARA 1, POSICIONA 2, MEDE 3, REPOSICIONA 4, TRANSMITE 5, AGUARDA A, PROX_DIGITO C, ESPERA E, FINAL F; unused codes → INICIAL, db_estado=B.
- INICIAL: zera=1; if ligar → PREPARA.
- PREPARA: zera=1; clears angulo, direcao, erro_medida and counters; → POSICIONA.
- POSICIONA:
  - settle counter increments every cycle.
  - If ligar=0 → FINAL immediately. This check applies here only; a frame in progress always completes.
  - Else when count==T_ASSENTA-1 → MEDE, counter cleared. Dwell is exactly T_ASSENTA cycles.
- MEDE: comeca_medida=1; clears indice_digito, erro_medida and watchdog; → AGUARDA.
- AGUARDA: watchdog increments.
  - If fim_medida: silencio=1 → REPOSICIONA, else → TRANSMITE.
  - Else if watchdog==T_MEDIDA-1: erro_medida←1 → REPOSICIONA.
  - fim_medida wins when both occur in the same cycle.
  - fim_medida in any other state is ignored.
- TRANSMITE: comeca_transmissao=1; → ESPERA.
- ESPERA: on fim_digito → PROX_DIGITO.
- PROX_DIGITO: if indice_digito==N_DIGITOS-1 → REPOSICIONA, else indice_digito+1 → TRANSMITE. Exactly N_DIGITOS comeca_transmissao pulses per frame.
- REPOSICIONA: fim_posicao=1, then update angulo and direcao:
  - modo=1 and angulo==N_POS-1 → FINAL, angulo unchanged.
  - direcao=0, angulo<N_POS-1 → angulo+1.
  - direcao=0, angulo==N_POS-1 → direcao←1, angulo-1.
  - direcao=1, angulo>0 → angulo-1.
  - direcao=1, angulo==0 → direcao←0, angulo+1.
  - angulo never leaves 0..N_POS-1. Otherwise → POSICIONA.
- FINAL: pronto=1; → INICIAL. angulo and erro_medida hold until the next PREPARA.
- erro_medida: level, held from set until the next MEDE or PREPARA.
- modo is sampled only in REPOSICIONA. ligar is sampled only in INICIAL and POSICIONA.

Decomposition:
- Package sonar_pkg: 4-bit state code constants (shared with the db_estado 7-segment decode) and a clog2 helper.
- Sub-module sonar_contador_m #(M): modulo-M counter with zera, conta, Q and fim (Q==M-1). Instantiated twice, for settle (T_ASSENTA) and watchdog (T_MEDIDA).
- Angle and digit registers live inline in the FSM.

Test Plan:
Parameters for all runs: N_POS=4, T_ASSENTA=3, N_DIGITOS=3, T_MEDIDA=10.
1. ligar=1, modo=0; every measurement gets fim_medida 2 cycles after comeca_medida, silencio=0, fim_digito 1 cycle after each transmit → angulo sequence 0,1,2,3,2,1,0,1; direcao toggles at 3 and 0; 3 comeca_transmissao per position with indice_digito 0,1,2; POSICIONA dwell 3 cycles.
2. modo=1, same stimulus → positions 0..3, then pronto pulses once, state F then 0, angulo holds 3.
3. Withhold fim_medida at angulo=1 → erro_medida=1 exactly 10 cycles after entering AGUARDA, no transmit, angulo→2; erro_medida clears at the next comeca_medida.
4. silencio=1 with fim_medida at angulo=2 → zero comeca_transmissao, fim_posicao pulse, angulo→3. Separately, fim_medida in the same cycle the watchdog expires → TRANSMITE, erro_medida=0.
5. Drop ligar during ESPERA → the frame completes (3 characters), then REPOSICIONA, POSICIONA, FINAL in the first POSICIONA cycle, pronto=1.
6. Assert reset in ESPERA with angulo=2, direcao=1 → same cycle: db_estado=0, angulo=0, direcao=0, indice_digito=0, zera=1; ligar restarts the sweep from 0.
